// File: rtl/cam_match_responder_if.sv
// Search/response bus of the CAM word store: write port, mismatch lines and the
// resolver's valid/ready response stream. MATCH_COUNT_EN adds the match_count signal.
interface cam_match_responder_if #(
    parameter int AW = 4
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          search_valid;
    logic [63:0]   mismatch_lines;
    logic          busy;
    logic          any_match;
    logic          resp_valid;
    logic          resp_ready;
    logic [AW-1:0] resp_addr;
    logic          done;
`ifdef MATCH_COUNT_EN
    logic [AW:0]   match_count;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, search_valid, mismatch_lines, resp_ready,
`ifdef MATCH_COUNT_EN
        input  match_count,
`endif
        input  busy, any_match, resp_valid, resp_addr, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, search_valid, mismatch_lines, resp_ready,
`ifdef MATCH_COUNT_EN
        output match_count,
`endif
        output busy, any_match, resp_valid, resp_addr, done
    );
endinterface

// File: rtl/cam_match_responder.sv
// CAM word store with tag latch and lowest-index-first multiple-match resolver.
// Optional MATCH_COUNT_EN: adds match_count, the number of tags still to be streamed.
module cam_match_responder #(
    parameter int WORDS = 16,
    parameter int AW    = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    cam_match_responder_if.slave    bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_STREAM = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [31:0]        mem_q [WORDS];
    logic [31:0]        mem_d [WORDS];
    logic [WORDS-1:0]   tags_q, tags_d;
    logic [WORDS-1:0]   match_s;
    logic [WORDS-1:0]   remain_s;
    logic               busy_q, busy_d;
    logic               any_match_q, any_match_d;
    logic               resp_valid_q, resp_valid_d;
    logic [AW-1:0]      resp_addr_q, resp_addr_d;
    logic               done_q, done_d;
`ifdef MATCH_COUNT_EN
    logic [AW:0]        match_count_q, match_count_d;
`endif

    function automatic logic [AW-1:0] lowest_set(input logic [WORDS-1:0] v);
        logic [AW-1:0] idx;
        idx = {AW{1'b0}};
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = AW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

`ifdef MATCH_COUNT_EN
    function automatic logic [AW:0] popcount(input logic [WORDS-1:0] v);
        logic [AW:0] cnt;
        cnt = {(AW+1){1'b0}};
        for (int i = 0; i < WORDS; i++) begin
            cnt = cnt + {{AW{1'b0}}, v[i]};
        end
        return cnt;
    endfunction
`endif

    // Per-word match against the mismatch lines; an idle bus pair never mismatches.
    always_comb begin
        for (int i = 0; i < WORDS; i++) begin
            logic mm;
            mm = 1'b0;
            for (int b = 0; b < 32; b++) begin
                mm = mm | (bus.mismatch_lines[2*b] & ~mem_q[i][b])
                        | (bus.mismatch_lines[2*b+1] & mem_q[i][b]);
            end
            match_s[i] = ~mm;
        end
    end

    // Tag set left after the currently presented address is consumed.
    always_comb begin
        remain_s = tags_q;
        remain_s[resp_addr_q] = 1'b0;
    end

    // Next-state: write port, tag latch and resolver stepping.
    always_comb begin
        mem_d         = mem_q;
        state_d       = state_q;
        tags_d        = tags_q;
        busy_d        = busy_q;
        any_match_d   = any_match_q;
        resp_valid_d  = resp_valid_q;
        resp_addr_d   = resp_addr_q;
        done_d        = 1'b0;
`ifdef MATCH_COUNT_EN
        match_count_d = match_count_q;
`endif
        if (bus.wr_en) begin
            mem_d[bus.wr_addr] = bus.wr_data;
        end else begin
            mem_d = mem_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.search_valid) begin
                    tags_d = match_s;
`ifdef MATCH_COUNT_EN
                    match_count_d = popcount(match_s);
`endif
                    if (|match_s) begin
                        state_d      = ST_STREAM;
                        busy_d       = 1'b1;
                        any_match_d  = 1'b1;
                        resp_valid_d = 1'b1;
                        resp_addr_d  = lowest_set(match_s);
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    tags_d = tags_q;
                end
            end
            ST_STREAM: begin
                if (resp_valid_q && bus.resp_ready) begin
                    tags_d = remain_s;
`ifdef MATCH_COUNT_EN
                    match_count_d = match_count_q - {{AW{1'b0}}, 1'b1};
`endif
                    if (|remain_s) begin
                        resp_addr_d = lowest_set(remain_s);
                    end else begin
                        state_d      = ST_IDLE;
                        busy_d       = 1'b0;
                        any_match_d  = 1'b0;
                        resp_valid_d = 1'b0;
                        resp_addr_d  = {AW{1'b0}};
                        done_d       = 1'b1;
                    end
                end else begin
                    tags_d = tags_q;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                busy_d       = 1'b0;
                any_match_d  = 1'b0;
                resp_valid_d = 1'b0;
                resp_addr_d  = {AW{1'b0}};
            end
        endcase
    end

    // State, storage and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
            tags_q       <= {WORDS{1'b0}};
            busy_q       <= 1'b0;
            any_match_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= {AW{1'b0}};
            done_q       <= 1'b0;
`ifdef MATCH_COUNT_EN
            match_count_q <= {(AW+1){1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            tags_q       <= tags_d;
            busy_q       <= busy_d;
            any_match_q  <= any_match_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            done_q       <= done_d;
`ifdef MATCH_COUNT_EN
            match_count_q <= match_count_d;
`endif
        end
    end

    assign bus.busy       = busy_q;
    assign bus.any_match  = any_match_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_addr  = resp_addr_q;
    assign bus.done       = done_q;
`ifdef MATCH_COUNT_EN
    assign bus.match_count = match_count_q;
`endif
endmodule

// File: tb/tb_cam_match_responder.sv
// Directed bench for cam_match_responder (WORDS=16): full match, selective match,
// no match, back-pressure, write/search overlap and mid-stream reset.
module tb_cam_match_responder;
    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    int   checks = 0;
    int   errors = 0;

    cam_match_responder_if #(.AW(4)) bus ();

    cam_match_responder #(.WORDS(16), .AW(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_lines(input logic [31:0] c, input logic [31:0] m);
        logic [63:0] l;
        l = 64'h0;
        for (int b = 0; b < 32; b++) begin
            l[2*b]   = m[b] & c[b];
            l[2*b+1] = m[b] & ~c[b];
        end
        return l;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input logic [3:0] a, input logic [31:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic search(input logic [31:0] c, input logic [31:0] m);
        bus.search_valid   = 1'b1;
        bus.mismatch_lines = mk_lines(c, m);
        tick();
        bus.search_valid   = 1'b0;
        bus.mismatch_lines = 64'h0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  64'(bus.busy), 64'd0);
        check({tag, "_any"},   64'(bus.any_match), 64'd0);
        check({tag, "_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_addr"},  64'(bus.resp_addr), 64'd0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 32'h0;
        bus.search_valid = 1'b0; bus.mismatch_lines = 64'h0; bus.resp_ready = 1'b0;

        // Reset
        #2 RST_N = 1'b0;
        repeat (2) tick();
        check_idle("rst");
        check("rst_done", 64'(bus.done), 64'd0);
        RST_N = 1'b1;
        tick();

        // 1: all-zero lines -> every word responds
        bus.resp_ready = 1'b1;
        bus.search_valid = 1'b1;
        bus.mismatch_lines = 64'h0;
        tick();
        bus.search_valid = 1'b0;
        check("t1_busy", 64'(bus.busy), 64'd1);
        check("t1_any",  64'(bus.any_match), 64'd1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t1_valid%0d", i), 64'(bus.resp_valid), 64'd1);
            check($sformatf("t1_addr%0d", i),  64'(bus.resp_addr), 64'(i));
            check($sformatf("t1_nodone%0d", i), 64'(bus.done), 64'd0);
            tick();
        end
        check("t1_done", 64'(bus.done), 64'd1);
        check_idle("t1_end");
        tick();
        check("t1_done_pulse", 64'(bus.done), 64'd0);

        // 2: selective match
        write_word(4'd3, 32'hA5A5_A5A5);
        write_word(4'd9, 32'hA5A5_A5A5);
        write_word(4'd5, 32'h5A5A_5A5A);
        search(32'hA5A5_A5A5, 32'hFFFF_FFFF);
        check("t2_v0", 64'(bus.resp_valid), 64'd1);
        check("t2_a0", 64'(bus.resp_addr), 64'd3);
`ifdef MATCH_COUNT_EN
        check("t2_cnt0", 64'(bus.match_count), 64'd2);
`endif
        tick();
        check("t2_a1", 64'(bus.resp_addr), 64'd9);
        check("t2_any1", 64'(bus.any_match), 64'd1);
`ifdef MATCH_COUNT_EN
        check("t2_cnt1", 64'(bus.match_count), 64'd1);
`endif
        tick();
        check("t2_done", 64'(bus.done), 64'd1);
        check_idle("t2_end");
`ifdef MATCH_COUNT_EN
        check("t2_cnt2", 64'(bus.match_count), 64'd0);
`endif

        // 3: no match -> done only
        search(32'hDEAD_BEEF, 32'hFFFF_FFFF);
        check("t3_done", 64'(bus.done), 64'd1);
        check_idle("t3");
        tick();
        check("t3_done_pulse", 64'(bus.done), 64'd0);
        check("t3_busy2", 64'(bus.busy), 64'd0);

        // 4: back-pressure 1,0,0,1 with an ignored search mid-stream
        bus.resp_ready = 1'b1;
        search(32'hA5A5_A5A5, 32'hFFFF_FFFF);
        check("t4_a0", 64'(bus.resp_addr), 64'd3);
        tick();
        check("t4_a1", 64'(bus.resp_addr), 64'd9);
        bus.resp_ready = 1'b0;
        bus.search_valid = 1'b1;
        bus.mismatch_lines = 64'h0;
        tick();
        bus.search_valid = 1'b0;
        check("t4_stall1_v", 64'(bus.resp_valid), 64'd1);
        check("t4_stall1_a", 64'(bus.resp_addr), 64'd9);
        tick();
        check("t4_stall2_v", 64'(bus.resp_valid), 64'd1);
        check("t4_stall2_a", 64'(bus.resp_addr), 64'd9);
        bus.resp_ready = 1'b1;
        tick();
        check("t4_done", 64'(bus.done), 64'd1);
        check_idle("t4_end");
        tick();
        check("t4_noqueue", 64'(bus.resp_valid), 64'd0);

        // 5: write in the same cycle as search compares old contents
        bus.wr_en = 1'b1; bus.wr_addr = 4'd9; bus.wr_data = 32'h0;
        search(32'hA5A5_A5A5, 32'hFFFF_FFFF);
        bus.wr_en = 1'b0;
        check("t5_a0", 64'(bus.resp_addr), 64'd3);
        tick();
        check("t5_a1", 64'(bus.resp_addr), 64'd9);
        check("t5_v1", 64'(bus.resp_valid), 64'd1);
        tick();
        check("t5_done", 64'(bus.done), 64'd1);
        search(32'hA5A5_A5A5, 32'hFFFF_FFFF);
        check("t5_r_a0", 64'(bus.resp_addr), 64'd3);
        tick();
        check("t5_r_done", 64'(bus.done), 64'd1);
        check("t5_r_valid", 64'(bus.resp_valid), 64'd0);

        // 6: asynchronous reset mid-stream
        bus.resp_ready = 1'b0;
        search(32'hA5A5_A5A5, 32'hFFFF_FFFF);
        check("t6_v_pre", 64'(bus.resp_valid), 64'd1);
        #2 RST_N = 1'b0;
        #1;
        check_idle("t6_async");
        tick();
        check("t6_nodone", 64'(bus.done), 64'd0);
        RST_N = 1'b1;
        tick();
        check("t6_nodone2", 64'(bus.done), 64'd0);
        check_idle("t6_after");
        // Cleared memory: comparand 0 with full mask matches every word
        bus.resp_ready = 1'b1;
        search(32'h0, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("t6_addr%0d", i), 64'(bus.resp_addr), 64'(i));
            tick();
        end
        check("t6_done", 64'(bus.done), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
